// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request, scoreboard query and register-file write bus
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 5
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      reserve_valid;
  logic [ADDR_W-1:0]         reserve_addr;
  logic [ADDR_W-1:0]         rs_sel;
  logic [ADDR_W-1:0]         rt_sel;
  logic                      rs_busy;
  logic                      rt_busy;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  modport master (
    output req_valid, req_addr, req_data, reserve_valid, reserve_addr, rs_sel, rt_sel,
    input  req_ready, rs_busy, rt_busy, wr_en, wr_addr, wr_data
  );
  modport slave (
    input  req_valid, req_addr, req_data, reserve_valid, reserve_addr, rs_sel, rt_sel,
    output req_ready, rs_busy, rt_busy, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic                  clk,
  input logic                  reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]       r_ptr;
  logic [NUM_REGS-1:0] r_pending;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [PW-1:0]       w_g;
  logic                w_any;
  logic                w_hs;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [NUM_REGS-1:0] w_pend_nxt;
  // Scan from the highest offset down so the nearest valid index after r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_g   = PW'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end
  assign w_hs          = w_any & ~reset;
  assign w_addr        = bus.req_addr[int'(w_g) * ADDR_W +: ADDR_W];
  assign w_data        = bus.req_data[int'(w_g) * DATA_W +: DATA_W];
  assign bus.req_ready = w_hs ? NUM_REQ'(1) << w_g : '0;
  // Clear before set so a new reservation of the register just written stays pending
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_hs) w_pend_nxt[w_addr] = 1'b0;
    if (bus.reserve_valid) w_pend_nxt[bus.reserve_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr     <= '0;
      r_pending <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_pending <= w_pend_nxt;
      r_wr_en   <= w_hs && w_addr != '0;
      if (w_hs) r_ptr <= (w_g == PW'(NUM_REQ - 1)) ? '0 : PW'(w_g + 1'b1);
      if (w_hs && w_addr != '0) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
    end
  end
  assign bus.rs_busy = r_pending[bus.rs_sel];
  assign bus.rt_busy = r_pending[bus.rt_sel];
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks against a behavioural model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int m_ptr = 0;
  bit m_pend [32];
  bit m_wen = 1'b0;
  logic [4:0] m_waddr = '0;
  logic [63:0] m_wdata = '0;

  regfile_wb_arbiter_if #(.NUM_REQ(3), .DATA_W(64), .ADDR_W(5)) bus ();
  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(64), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    if (reset) return -1;
    for (int k = 0; k < 3; k++)
      if (bus.req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    int g = m_grant();
    return g < 0 ? 3'b000 : 3'b001 << g;
  endfunction

  task automatic m_clock();
    int g = m_grant();
    logic [4:0] a;
    if (reset) begin
      m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
      foreach (m_pend[i]) m_pend[i] = 0;
      return;
    end
    m_wen = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % 3;
      a = bus.req_addr[g*5 +: 5];
      if (a != 0) begin
        m_wen = 1; m_waddr = a; m_wdata = bus.req_data[g*64 +: 64];
        m_pend[a] = 0;
      end
    end
    if (bus.reserve_valid && bus.reserve_addr != 0) m_pend[bus.reserve_addr] = 1;
  endtask

  task automatic tick();
    m_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.req_valid[i] = v;
    bus.req_addr[i*5 +: 5] = a;
    bus.req_data[i*64 +: 64] = d;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (bus.req_ready !== 3'b000) $display("FAIL reset_ready cyc%0d got %b want 000", c, bus.req_ready);
      else passed++;
      tick();
    end
    reset = 1'b0;
    bus.req_valid = 3'b000;
    #1;
    total++;
    if (bus.wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", bus.wr_en);
    else passed++;
    for (int i = 0; i < 32; i++) begin
      bus.rs_sel = 5'(i);
      bus.rt_sel = 5'(31 - i);
      #1;
      total++;
      if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b0)
        $display("FAIL reset_busy sel%0d got %b%b want 00", i, bus.rs_busy, bus.rt_busy);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 64'hA + 64'(i));
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (bus.req_ready !== 3'b001 << (c % 3)) $display("FAIL rr_grant cyc%0d got %b want %b", c, bus.req_ready, 3'b001 << (c % 3));
      else passed++;
      tick();
      total++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 5'(c % 3 + 1) || bus.wr_data !== 64'hA + 64'(c % 3))
        $display("FAIL rr_write cyc%0d got en%b a%0d d%h want en1 a%0d d%h", c, bus.wr_en, bus.wr_addr, bus.wr_data, c % 3 + 1, 64'hA + 64'(c % 3));
      else passed++;
    end
  endtask

  task automatic test_pointer_skip();
    logic [2:0] want [3] = '{3'b001, 3'b001, 3'b100};
    logic [2:0] vals [3] = '{3'b001, 3'b001, 3'b101};
    for (int c = 0; c < 3; c++) begin
      bus.req_valid = vals[c];
      #1;
      total++;
      if (bus.req_ready !== want[c]) $display("FAIL skip_grant step%0d got %b want %b", c, bus.req_ready, want[c]);
      else passed++;
      tick();
    end
    bus.req_valid = 3'b000;
  endtask

  task automatic test_scoreboard();
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd7;
    tick();
    bus.reserve_valid = 1'b0;
    bus.rs_sel = 5'd7;
    #1;
    total++;
    if (bus.rs_busy !== 1'b1) $display("FAIL sb_reserved got %b want 1", bus.rs_busy);
    else passed++;
    set_req(1, 1'b1, 5'd7, 64'h55);
    #1;
    total++;
    if (bus.req_ready !== 3'b010 || bus.rs_busy !== 1'b1)
      $display("FAIL sb_accept got ready%b busy%b want ready010 busy1", bus.req_ready, bus.rs_busy);
    else passed++;
    tick();
    bus.req_valid = 3'b000;
    #1;
    total++;
    if (bus.rs_busy !== 1'b0 || bus.wr_en !== 1'b1 || bus.wr_addr !== 5'd7 || bus.wr_data !== 64'h55)
      $display("FAIL sb_written got busy%b en%b a%0d d%h want busy0 en1 a7 d55", bus.rs_busy, bus.wr_en, bus.wr_addr, bus.wr_data);
    else passed++;
  endtask

  task automatic test_set_clear();
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd9;
    tick();
    set_req(1, 1'b1, 5'd9, 64'h99);
    tick();
    bus.req_valid = 3'b000;
    bus.reserve_valid = 1'b0;
    bus.rs_sel = 5'd9;
    #1;
    total++;
    if (bus.rs_busy !== 1'b1 || bus.wr_en !== 1'b1) $display("FAIL setclear_same got busy%b en%b want busy1 en1", bus.rs_busy, bus.wr_en);
    else passed++;
    set_req(0, 1'b1, 5'd9, 64'h9A);
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd10;
    tick();
    bus.req_valid = 3'b000;
    bus.reserve_addr = 5'd0;
    bus.rt_sel = 5'd10;
    #1;
    total++;
    if (bus.rs_busy !== 1'b0 || bus.rt_busy !== 1'b1) $display("FAIL setclear_diff got rs%b rt%b want rs0 rt1", bus.rs_busy, bus.rt_busy);
    else passed++;
    tick();
    bus.reserve_valid = 1'b0;
    bus.rs_sel = 5'd0;
    #1;
    total++;
    if (bus.rs_busy !== 1'b0) $display("FAIL r0_reserve got %b want 0", bus.rs_busy);
    else passed++;
    set_req(2, 1'b1, 5'd0, 64'hDEAD);
    #1;
    total++;
    if (bus.req_ready !== m_ready() || bus.req_ready === 3'b000) $display("FAIL r0_ready got %b want %b", bus.req_ready, m_ready());
    else passed++;
    tick();
    bus.req_valid = 3'b000;
    total++;
    if (bus.wr_en !== 1'b0) $display("FAIL r0_drop got wr_en %b want 0", bus.wr_en);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    bus.reserve_valid = 1'b1; bus.reserve_addr = 5'd4;
    set_req(0, 1'b1, 5'd3, 64'h1);
    tick();
    bus.reserve_valid = 1'b0;
    bus.req_valid = 3'b110;
    set_req(1, 1'b1, 5'd5, 64'h5);
    set_req(2, 1'b1, 5'd6, 64'h6);
    bus.rs_sel = 5'd4;
    #1;
    total++;
    if (bus.rs_busy !== 1'b1) $display("FAIL mid_pending_pre got %b want 1", bus.rs_busy);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 3'b000) $display("FAIL mid_ready got %b want 000", bus.req_ready);
    else passed++;
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (bus.wr_en !== 1'b0 || bus.rs_busy !== 1'b0) $display("FAIL mid_after got en%b busy%b want en0 busy0", bus.wr_en, bus.rs_busy);
    else passed++;
    total++;
    if (bus.req_ready !== 3'b010) $display("FAIL mid_first_grant got %b want 010", bus.req_ready);
    else passed++;
    tick();
    bus.req_valid = 3'b000;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int g;
      for (int i = 0; i < 3; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), {$urandom, $urandom});
      bus.reserve_valid = ($urandom_range(0, 2) == 0);
      bus.reserve_addr = 5'($urandom);
      bus.rs_sel = 5'($urandom);
      bus.rt_sel = 5'($urandom);
      reset = ($urandom_range(0, 60) == 0);
      #1;
      total++;
      if (bus.req_ready !== m_ready() || bus.rs_busy !== m_pend[bus.rs_sel] || bus.rt_busy !== m_pend[bus.rt_sel])
        $display("FAIL rnd_comb cyc%0d got ready%b rs%b rt%b want ready%b rs%b rt%b", c, bus.req_ready, bus.rs_busy, bus.rt_busy, m_ready(), m_pend[bus.rs_sel], m_pend[bus.rt_sel]);
      else passed++;
      g = m_grant();
      tick();
      total++;
      if (bus.wr_en !== m_wen || bus.wr_addr !== m_waddr || bus.wr_data !== m_wdata)
        $display("FAIL rnd_write cyc%0d got en%b a%0d d%h want en%b a%0d d%h", c, bus.wr_en, bus.wr_addr, bus.wr_data, m_wen, m_waddr, m_wdata);
      else passed++;
      if (g >= 0) bus.req_valid[g] = 1'b0;
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bus.reserve_valid = 1'b0; bus.reserve_addr = '0;
    bus.rs_sel = '0; bus.rt_sel = '0;
    foreach (m_pend[i]) m_pend[i] = 0;
    test_reset();
    test_round_robin();
    test_pointer_skip();
    test_scoreboard();
    test_set_clear();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback arbiter and scoreboard in front of the 32-entry register file's single write port. It shares that port round-robin between NUM_REQ writeback sources (ALU, load, multiply) using valid/ready handshakes, and registers the winning write for one cycle. It also tracks registers with outstanding writes so decode can query rs/rt hazards.

Parameters:
NUM_REQ, 3, number of writeback requesters (index 0 = ALU, 1 = load, 2 = multiply)
DATA_W, 64, write data width
ADDR_W, 5, register address width
NUM_REGS, 32, register count (= 2**ADDR_W)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request valid
req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i]
reserve_valid  input  1  decode issued an instruction that will write reserve_addr
reserve_addr  input  ADDR_W  destination being reserved
rs_sel  input  ADDR_W  hazard query address A
rt_sel  input  ADDR_W  hazard query address B
rs_busy  output  1  rs_sel has an outstanding write
rt_busy  output  1  rt_sel has an outstanding write
wr_en  output  1  register file write strobe
wr_addr  output  ADDR_W  register file write address
wr_data  output  DATA_W  register file write data

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high: when reset=1 at posedge, state clears.
- Reset values: rr_ptr=0, pending=0, wr_en=0, wr_addr=0, wr_data=0.
- req_ready is forced to 0 while reset=1. rs_busy and rt_busy read 0 after reset.
- Arbitration (combinational):
  - Search indices rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - The first index with req_valid=1 is the grant g; req_ready = one-hot(g).
  - If no request is valid, req_ready = 0.
  - req_ready must not depend on req_data or req_addr.
- Pointer update: on a grant, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Write path latency = 1 cycle. At posedge after a handshake:
  - If req_addr[g] != 0: wr_en<=1, wr_addr<=req_addr[g], wr_data<=req_data[g].
  - If req_addr[g] == 0: the request is consumed but dropped; wr_en<=0.
  - With no handshake, wr_en<=0; wr_addr and wr_data hold their last values.
- Throughput: one write per cycle. The register file never back-pressures.
- A requester holds valid, addr and data stable until its handshake completes.
- Scoreboard: pending[NUM_REGS-1:0]. pending[0] is hard-wired 0.
  - Set: reserve_valid=1 and reserve_addr != 0 sets pending[reserve_addr] at posedge.
  - Clear: a handshake to address a != 0 clears pending[a] at posedge (at acceptance, not at wr_en).
  - Same address set and cleared in the same cycle: set wins, because a new producer is outstanding.
  - Different addresses set and cleared in the same cycle: both take effect.
  - Reserve of an already-pending register leaves it set; multiple in-flight writers per register are not counted.
  - Decode must stall rather than issue a second writer to a pending register.
- Hazard outputs (combinational from registered pending only):
  - rs_busy = pending[rs_sel]; rt_busy = pending[rt_sel].
  - A write accepted in the current cycle still reads busy; it reads not-busy from the next cycle, coinciding with wr_en.
- Reset mid-operation:
  - Requests presented during reset are not granted and their transfers are lost.
  - wr_en is 0 in the cycle after reset.
  - All pending bits clear. Decode re-issues after reset.

Test Plan:
- Reset then idle: hold reset 2 cycles with req_valid=3'b111 -> req_ready=0 during reset. After reset: wr_en=0, rs_busy=rt_busy=0 for all rs_sel/rt_sel.
- Round-robin fairness: req_valid=3'b111 held 6 cycles, addrs 1/2/3, data 'hA/'hB/'hC -> grants 0,1,2,0,1,2. wr_addr sequence 1,2,3,1,2,3 one cycle later; wr_data 'hA,'hB,'hC repeating.
- Pointer skip: after grant 0, req_valid=3'b001 -> grant 0 again (rr_ptr=1, indices 1 and 2 idle). Next cycle req_valid=3'b101 -> grant 2.
- Scoreboard lifecycle:
  - reserve_valid=1, reserve_addr=7 -> rs_sel=7 reads rs_busy=1 next cycle.
  - Requester 1 writes addr 7, data 'h55 -> rs_busy=1 in the accept cycle; the following cycle rs_busy=0, wr_en=1, wr_addr=7, wr_data='h55.
- Simultaneous set/clear and r0:
  - Accept write to 9 while reserve_addr=9 -> pending[9] stays 1.
  - reserve_addr=0 -> rs_sel=0 reads rs_busy=0.
  - Request to addr 0 -> req_ready=1, no wr_en pulse.
- Reset mid-stream: assert reset while req_valid=3'b110 with pending[4]=1 -> next cycle wr_en=0 and pending[4]=0. First grant after deassert goes to requester 1 (rr_ptr=0, requester 0 idle).
